// File: rtl/bcd_updown_counter_mux_pkg.sv
// Shared constants for the multiplexed BCD counter: digit width and the
// active-low {a,b,c,d,e,f,g,dp} seven-segment patterns.
package bcd_updown_counter_mux_pkg;

    localparam int BCD_W = 4;

    localparam logic [7:0] SEG_0     = 8'h03;
    localparam logic [7:0] SEG_1     = 8'h9F;
    localparam logic [7:0] SEG_2     = 8'h25;
    localparam logic [7:0] SEG_3     = 8'h0D;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h49;
    localparam logic [7:0] SEG_6     = 8'h41;
    localparam logic [7:0] SEG_7     = 8'h1F;
    localparam logic [7:0] SEG_8     = 8'h01;
    localparam logic [7:0] SEG_9     = 8'h09;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] seg_pattern(input logic [BCD_W-1:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Non-BCD nibbles collapse to zero so the counter never holds an illegal digit.
    function automatic logic [BCD_W-1:0] bcd_sanitize(input logic [BCD_W-1:0] d);
        return (d > 4'd9) ? 4'd0 : d;
    endfunction

endpackage

// File: rtl/bcd_updown_counter_mux_seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder with a blank override.
module seg7_decode
    import bcd_updown_counter_mux_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    input  logic             blank,
    output logic [7:0]       seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            seg = seg_pattern(digit);
        end
    end

endmodule

// File: rtl/bcd_updown_counter_mux.sv
// N-digit BCD up/down counter with programmable step prescaler, parallel load,
// wrap carry pulse and a time-multiplexed seven-segment / anode driver.
module bcd_updown_counter_mux
    import bcd_updown_counter_mux_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 50_000,
    parameter int BLANK_LZ = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    upDown,
    input  logic                    load,
    input  logic [4*DIGITS-1:0]     loadValue,
    output logic [4*DIGITS-1:0]     count,
    output logic                    carry,
    output logic [7:0]              sevenSegment,
    output logic [DIGITS-1:0]       anode
);

    localparam int CW = DIGITS * BCD_W;
    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]      scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [CW-1:0]      count_q, count_d;
    logic               carry_q, carry_d;
    logic [DIGITS-1:0]  anode_q, anode_d;
    logic [7:0]         seg_q, seg_d;

    logic               tick;
    logic               scan_adv;
    logic [DIGITS:0]    term_chain;
    logic [DIGITS:0]    zero_above;
    logic [DIGITS-1:0]  blank_vec;
    logic [CW-1:0]      step_val;
    logic [CW-1:0]      load_val;
    logic [BCD_W-1:0]   digit_sel;
    logic               blank_sel;
    logic [7:0]         seg_sel;

    // term_chain[i]: every digit below i sits at its terminal value for the
    // current direction. zero_above[k]: digit k and everything above it are 0.
    always_comb begin
        term_chain[0]      = 1'b1;
        zero_above[DIGITS] = 1'b1;
        blank_vec          = '0;
        for (int i = 0; i < DIGITS; i++) begin
            term_chain[i+1] = term_chain[i] &
                (upDown ? (count_q[i*BCD_W +: BCD_W] == 4'd9)
                        : (count_q[i*BCD_W +: BCD_W] == 4'd0));
        end
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_above[k] = zero_above[k+1] & (count_q[k*BCD_W +: BCD_W] == 4'd0);
            blank_vec[k]  = (BLANK_LZ != 0) && (k > 0) && zero_above[k];
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        logic [BCD_W-1:0] cur;
        logic [BCD_W-1:0] nxt;
        assign cur = count_q[g*BCD_W +: BCD_W];
        assign nxt = upDown ? ((cur == 4'd9) ? 4'd0 : cur + 4'd1)
                            : ((cur == 4'd0) ? 4'd9 : cur - 4'd1);
        assign step_val[g*BCD_W +: BCD_W] = (tick && term_chain[g]) ? nxt : cur;
        assign load_val[g*BCD_W +: BCD_W] = bcd_sanitize(loadValue[g*BCD_W +: BCD_W]);
    end

    always_comb begin
        tick       = en && (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick_cnt_q;
        if (load || tick) begin
            tick_cnt_d = '0;
        end else if (en) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end

        count_d = load ? load_val : step_val;
        carry_d = tick && !load && term_chain[DIGITS];

        scan_adv   = (scan_cnt_q == SCAN_LAST);
        scan_cnt_d = scan_adv ? '0 : scan_cnt_q + 1'b1;
        idx_d      = idx_q;
        if (scan_adv) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        digit_sel = '0;
        blank_sel = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                digit_sel = count_q[k*BCD_W +: BCD_W];
                blank_sel = blank_vec[k];
            end
        end
        anode_d = ~(DIGITS'(1) << idx_q);
        seg_d   = seg_sel;
    end

    seg7_decode u_seg7_decode (
        .digit (digit_sel),
        .blank (blank_sel),
        .seg   (seg_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            count_q    <= '0;
            carry_q    <= 1'b0;
            anode_q    <= ~DIGITS'(1);
            seg_q      <= SEG_0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            carry_q    <= carry_d;
            anode_q    <= anode_d;
            seg_q      <= seg_d;
        end
    end

    assign count        = count_q;
    assign carry        = carry_q;
    assign anode        = anode_q;
    assign sevenSegment = seg_q;

endmodule

// File: tb/tb_bcd_updown_counter_mux.sv
// Directed bench for bcd_updown_counter_mux with DIGITS=2, TICK_DIV=4, SCAN_DIV=3.
module tb_bcd_updown_counter_mux;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       upDown;
    logic       load;
    logic [7:0] loadValue;
    logic [7:0] count;
    logic       carry;
    logic [7:0] sevenSegment;
    logic [1:0] anode;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_updown_counter_mux #(
        .DIGITS   (2),
        .TICK_DIV (4),
        .SCAN_DIV (3),
        .BLANK_LZ (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .upDown       (upDown),
        .load         (load),
        .loadValue    (loadValue),
        .count        (count),
        .carry        (carry),
        .sevenSegment (sevenSegment),
        .anode        (anode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       up;
        logic       ld;
        logic [7:0] val;
        int         ncyc;
        logic [7:0] exp_cnt;
        logic       exp_c;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i, input logic e, input logic u, input logic l,
                           input logic [7:0] v, input int n, input logic [7:0] ec,
                           input logic cc);
        vecs[i].en      = e;
        vecs[i].up      = u;
        vecs[i].ld      = l;
        vecs[i].val     = v;
        vecs[i].ncyc    = n;
        vecs[i].exp_cnt = ec;
        vecs[i].exp_c   = cc;
    endtask

    initial begin
        logic [7:0] e;
        int         d;

        // Sequential records: state carries over from one to the next.
        set_vec(0,  1, 1, 1, 8'h99, 1, 8'h99, 0);
        set_vec(1,  1, 1, 0, 8'h00, 3, 8'h99, 0);
        set_vec(2,  1, 1, 0, 8'h00, 1, 8'h00, 1);
        set_vec(3,  1, 1, 0, 8'h00, 1, 8'h00, 0);
        set_vec(4,  1, 0, 1, 8'h00, 1, 8'h00, 0);
        set_vec(5,  1, 0, 0, 8'h00, 4, 8'h99, 1);
        set_vec(6,  1, 0, 0, 8'h00, 1, 8'h99, 0);
        set_vec(7,  1, 0, 1, 8'hA7, 1, 8'h07, 0);
        set_vec(8,  1, 0, 1, 8'h3F, 1, 8'h30, 0);
        set_vec(9,  1, 0, 1, 8'h10, 1, 8'h10, 0);
        set_vec(10, 1, 0, 0, 8'h00, 4, 8'h09, 0);
        set_vec(11, 1, 1, 0, 8'h00, 3, 8'h09, 0);
        set_vec(12, 1, 1, 1, 8'h42, 1, 8'h42, 0);
        set_vec(13, 1, 1, 0, 8'h00, 3, 8'h42, 0);
        set_vec(14, 1, 1, 0, 8'h00, 1, 8'h43, 0);

        rst_n = 1'b0; en = 1'b0; upDown = 1'b1; load = 1'b0; loadValue = 8'h00;
        run(2);
        check("reset_count", count, 8'h00);
        check("reset_carry", carry, 1'b0);
        check("reset_anode", anode, 2'b10);
        check("reset_seg",   sevenSegment, 8'h03);
        rst_n = 1'b1;

        en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            run(4);
            e = {4'(k / 10), 4'(k % 10)};
            check("count_up", count, e);
            check("count_up_carry", carry, 1'b0);
        end

        for (int i = 0; i < 15; i++) begin
            en        = vecs[i].en;
            upDown    = vecs[i].up;
            load      = vecs[i].ld;
            loadValue = vecs[i].val;
            run(vecs[i].ncyc);
            check("vec_count", count, vecs[i].exp_cnt);
            check("vec_carry", carry, vecs[i].exp_c);
        end
        load = 1'b0;

        // Asynchronous reset between edges while counting.
        run(2);
        check("pre_rst_count", count, 8'h43);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_count", count, 8'h00);
        check("async_rst_anode", anode, 2'b10);
        check("async_rst_seg",   sevenSegment, 8'h03);
        check("async_rst_carry", carry, 1'b0);
        #2 rst_n = 1'b1;

        // Scan phase is known from reset release: digit lit after edge k is ((k-1)/3)%2.
        en = 1'b0; upDown = 1'b1; load = 1'b1; loadValue = 8'h05;
        for (int k = 1; k <= 13; k++) begin
            run(1);
            if (k == 1) begin
                check("disp_load_count", count, 8'h05);
                check("disp_first_seg", sevenSegment, 8'h03);
                load = 1'b0;
            end else begin
                d = ((k - 1) / 3) % 2;
                check("disp_anode", anode, (d == 1) ? 2'b01 : 2'b10);
                check("disp_seg", sevenSegment, (d == 1) ? 8'hFF : 8'h49);
            end
        end

        // Hold mid-prescale with en low; scan keeps going.
        en = 1'b1;
        run(2);
        en = 1'b0;
        run(20);
        check("hold_count", count, 8'h05);
        check("hold_anode", anode, 2'b01);
        check("hold_seg", sevenSegment, 8'hFF);
        en = 1'b1;
        run(1);
        check("resume_wait", count, 8'h05);
        run(1);
        check("resume_step", count, 8'h06);
        upDown = 1'b0;
        run(4);
        check("dir_toggle", count, 8'h05);
        check("dir_toggle_carry", carry, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter_mux.md
# bcd_updown_counter_mux

Parametrised N-digit BCD up/down counter with a built-in multiplexed seven-segment driver: the multi-digit successor to the team's single-digit counter board demo. A programmable prescaler paces the count. The counter supports enable, synchronous parallel load, wrap-around carry/borrow and leading-zero blanking. A scan prescaler time-multiplexes all digits onto one active-low segment bus and one active-low anode bus.

## Interface
- DIGITS, 4: number of BCD digits and anodes (1..8).
- TICK_DIV, 50_000_000: clk cycles per count step (≥2).
- SCAN_DIV, 50_000: clk cycles each digit stays lit (≥2).
- BLANK_LZ, 1: 1 blanks leading zeros of digits DIGITS-1..1.

- clk  in  1: system clock. Single clock domain.
- rst_n  in  1: reset, asynchronous assert, active-low.
- en  in  1: count enable. While low, the tick prescaler holds.
- upDown  in  1: direction, 1 = up, 0 = down.
- load  in  1: synchronous parallel-load strobe.
- loadValue  in  4*DIGITS: BCD load value, digit 0 in [3:0].
- count  out  4*DIGITS: registered BCD count.
- carry  out  1: one-cycle pulse on wrap.
- sevenSegment  out  8: active-low {a,b,c,d,e,f,g,dp}, bit7 = a. dp is always 1.
- anode  out  DIGITS: active-low, exactly one bit low at any time after reset.

## Operation
- Tick prescaler counts 0..TICK_DIV-1 while en=1. tick=1 in the cycle it equals TICK_DIV-1, and it then returns to 0.
- On tick, digit i changes only if every lower digit is at its terminal value: 9 when counting up, 0 when counting down.
  - Up: 9→0, otherwise +1.
  - Down: 0→9, otherwise −1.
- Whole-counter wrap: all-9 → all-0 (up) or all-0 → all-9 (down). carry=1 for exactly the next cycle.
- Load has priority over tick:
  - count ← loadValue, with any nibble >9 replaced by 0.
  - The tick prescaler clears to 0.
  - carry stays 0.
- Scan prescaler counts 0..SCAN_DIV-1 continuously, independent of en. At its terminal value the scan index advances 0→1→…→DIGITS-1→0.
- Display path:
  - anode ← ~(1 << index).
  - sevenSegment ← decode(count digit[index]), from the live count.
  - Both are registered and update on the same edge.
- Blanking: with BLANK_LZ=1, digit k>0 shows 8'b11111111 when it and all higher digits are 0. Digit 0 is never blanked.
- Decode patterns, 0..9: 03, 9F, 25, 0D, 99, 49, 41, 1F, 01, 09 (hex). Any code >9 decodes to FF.

## Timing
- Reset values:
  - count = 0.
  - carry = 0.
  - both prescalers = 0.
  - scan index = 0.
  - anode = all ones except bit0 = 0.
  - sevenSegment = 8'h03.
- Count latency: count changes on the edge following the tick cycle. First step comes TICK_DIV cycles after en rises from a cleared prescaler.
- Load latency: count equals the sanitised loadValue one edge after load is sampled high.
- Display latency: a count change is visible on sevenSegment at the next scan advance of that digit, with at most DIGITS·SCAN_DIV cycles of staleness.
- en low mid-prescale holds the prescaler value. Toggling upDown takes effect on the next tick.
- rst_n low at any point forces all reset values immediately. Release is synchronous to clk.

## Structure
- Shared package holds:
  - segment pattern constants SEG_0..SEG_9, SEG_BLANK.
  - digit-width constant BCD_W = 4.
- Sub-module seg7_decode: combinational 4-bit → 8-bit active-low decoder, with blank input.
- Top-level contents:
  - both prescalers.
  - the BCD digit chain (generate loop over DIGITS).
  - scan index.
  - output registers.

## Test plan
Bench parameters: DIGITS=2, TICK_DIV=4, SCAN_DIV=3, BLANK_LZ=1.
- Reset then en=1, upDown=1 for 40 cycles → count steps 00,01,…,09,10 every 4 cycles. The 09→10 tens carry is correct.
- load=1, loadValue=8'h99, then one tick up → count=00, carry high for exactly 1 cycle. Same with loadValue=00 and upDown=0 → 99, carry pulse.
- loadValue=8'hA7 → count=07. load asserted in the tick cycle → load wins and no step occurs.
- count=05 with scan running → anode alternates 2'b10/2'b01 every 3 cycles. sevenSegment=49 on digit 0 and FF on digit 1 (leading zero blanked).
- en=0 for 20 cycles mid-prescale → count frozen, scan continues. Re-enable → step arrives after the remaining prescale cycles.
- rst_n pulsed low between edges during counting → count=00, anode=2'b10, sevenSegment=03 immediately, no carry.
